// File: rtl/soi_access_arb.sv
// soi_access_arb: owns one signal-of-interest register and serialises
// READ / WRITE / HOLD / RELEASE access to it among NUM_REQ requesters.
// Arbitration is round-robin while unlocked. While a lock is held, only the
// lock owner is eligible. Each response follows its accept by one cycle.
// Optional build macro SOI_ACCESS_STATS_EN adds the per-requester accept
// counters (acc_count) and the longest-stall tracker (stall_max).
module soi_access_arb #(
  parameter int          NUM_REQ = 4,
  parameter int          DATA_W  = 8,
  parameter logic [63:0] SOI_RST = 64'hFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         free_run,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [2*NUM_REQ-1:0]         req_op,
  input  logic [DATA_W*NUM_REQ-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [DATA_W-1:0]            soi_value,
  output logic                         soi_held,
`ifdef SOI_ACCESS_STATS_EN
  output logic [16*NUM_REQ-1:0]        acc_count,
  output logic [15:0]                  stall_max,
`endif
  output logic [$clog2(NUM_REQ)-1:0]   lock_owner
);

  localparam int          IW        = $clog2(NUM_REQ);
  localparam int unsigned NUM_REQ_U = NUM_REQ;
  localparam logic [IW-1:0]     LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [DATA_W-1:0] SOI_RST_V = SOI_RST[DATA_W-1:0];

  typedef enum logic {ST_RUN, ST_HELD} state_e;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_HOLD, OP_RELEASE} op_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [DATA_W-1:0]   soi_q, soi_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       gidx;
  logic [IW-1:0]       cand;
  logic                found;
  logic                accept;
  op_e                 op;

  logic [1:0]          op_a [NUM_REQ];
  logic [DATA_W-1:0]   wd_a [NUM_REQ];

  // Split the flat request buses into per-requester fields.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_a[g] = req_op[2*g +: 2];
    assign wd_a[g] = req_wdata[DATA_W*g +: DATA_W];
  end

  // Grant selection: owner-only while held, else first valid from rr_q.
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    if (!rst) begin
      if (state_q == ST_HELD) begin
        if (req_valid[owner_q]) begin
          grant[owner_q] = 1'b1;
          gidx           = owner_q;
        end
      end else begin
        for (int unsigned k = 0; k < NUM_REQ_U; k++) begin
          cand = IW'((32'(rr_q) + k) % NUM_REQ_U);
          if (!found && req_valid[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            gidx        = cand;
          end
        end
      end
    end
  end

  assign accept = |grant;
  assign op     = op_e'(op_a[gidx]);

  // Next-state for lock FSM, rr pointer, SOI and the response pipeline.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    soi_d       = soi_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;

    if (accept) begin
      rr_d        = (gidx == LAST_IDX) ? '0 : gidx + IW'(1);
      rsp_valid_d = grant;
      rsp_rdata_d = soi_q;
      rsp_err_d   = (state_q == ST_RUN) && (op == OP_RELEASE);
      case (op)
        OP_HOLD: begin
          if (state_q == ST_RUN) begin
            state_d = ST_HELD;
            owner_d = gidx;
          end
        end
        OP_RELEASE: begin
          if (state_q == ST_HELD) begin
            state_d = ST_RUN;
            owner_d = '0;
          end
        end
        default: ;
      endcase
    end

    // A write wins over the toggle; toggling resumes from the written value.
    if (accept && (op == OP_WRITE)) begin
      soi_d = wd_a[gidx];
    end else if ((state_q == ST_RUN) && free_run) begin
      soi_d = ~soi_q;
    end
  end

  // Lock FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      owner_q     <= '0;
      rr_q        <= '0;
      soi_q       <= SOI_RST_V;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      soi_q       <= soi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign soi_value  = soi_q;
  assign soi_held   = (state_q == ST_HELD);
  assign lock_owner = owner_q;

`ifdef SOI_ACCESS_STATS_EN
  logic [15:0] acc_q [NUM_REQ];
  logic [15:0] run_q [NUM_REQ];
  logic [15:0] run_d [NUM_REQ];
  logic [15:0] stall_max_q, stall_max_d;

  // Per-requester stall run length and the running maximum over all of them.
  always_comb begin
    stall_max_d = stall_max_q;
    for (int unsigned i = 0; i < NUM_REQ_U; i++) begin
      run_d[i] = '0;
      if (req_valid[i] && !grant[i]) begin
        run_d[i] = (run_q[i] == '1) ? run_q[i] : run_q[i] + 16'd1;
      end
      if (run_d[i] > stall_max_d) begin
        stall_max_d = run_d[i];
      end
    end
  end

  // Saturating accept counters and stall trackers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ_U; i++) begin
        acc_q[i] <= '0;
        run_q[i] <= '0;
      end
      stall_max_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ_U; i++) begin
        if (grant[i] && (acc_q[i] != '1)) begin
          acc_q[i] <= acc_q[i] + 16'd1;
        end
        run_q[i] <= run_d[i];
      end
      stall_max_q <= stall_max_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_acc_out
    assign acc_count[16*g +: 16] = acc_q[g];
  end
  assign stall_max = stall_max_q;
`endif

endmodule

// File: tb/tb_soi_access_arb.sv
// Directed testbench for soi_access_arb (NUM_REQ=4, DATA_W=8, SOI_RST=FF).
// Inputs change on the falling edge; outputs are checked shortly after.
module tb_soi_access_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        free_run;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [7:0]  soi_value;
  logic        soi_held;
  logic [1:0]  lock_owner;
`ifdef SOI_ACCESS_STATS_EN
  logic [63:0] acc_count;
  logic [15:0] stall_max;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [3:0] exp_g [6];
  logic [7:0] exp_d [6];

  soi_access_arb #(
    .NUM_REQ (4),
    .DATA_W  (8),
    .SOI_RST (64'hFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .free_run   (free_run),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .soi_value  (soi_value),
    .soi_held   (soi_held),
`ifdef SOI_ACCESS_STATS_EN
    .acc_count  (acc_count),
    .stall_max  (stall_max),
`endif
    .lock_owner (lock_owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_g = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
    exp_d = '{8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'hA5};

    rst = 1'b1; free_run = 1'b0; req_valid = '0; req_op = '0; req_wdata = '0;
    repeat (2) @(negedge clk);

    // Reset: nothing is granted even with every requester asking.
    req_valid = 4'hF; free_run = 1'b1; #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_soi", 32'(soi_value), 32'hFF);
    chk("rst_held", 32'(soi_held), 32'h0);
    chk("rst_owner", 32'(lock_owner), 32'h0);
    chk("rst_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    #1 chk("rst_soi_held_clk", 32'(soi_value), 32'hFF);

    // Free run: FF,00,FF,00.
    @(negedge clk);
    rst = 1'b0; free_run = 1'b1; req_valid = '0; #1;
    chk("fr0", 32'(soi_value), 32'hFF);
    @(negedge clk); #1 chk("fr1", 32'(soi_value), 32'h00);
    @(negedge clk); #1 chk("fr2", 32'(soi_value), 32'hFF);
    @(negedge clk); #1 chk("fr3", 32'(soi_value), 32'h00);

    // Req1 WRITE 5A while free-running.
    @(negedge clk);
    req_valid = 4'b0010; req_op = 8'h04; req_wdata = 32'h0000_5A00; #1;
    chk("wr_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0; #1;
    chk("wr_soi", 32'(soi_value), 32'h5A);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("wr_rdata", 32'(rsp_rdata), 32'hFF);
    chk("wr_err", 32'(rsp_err), 32'h0);
    @(negedge clk); #1;
    chk("wr_soi_toggle", 32'(soi_value), 32'hA5);
    chk("wr_rsp_drop", 32'(rsp_valid), 32'h0);

    // Req3 READ alone brings rr back to 0.
    req_valid = 4'b1000; req_op = 8'h00; #1;
    chk("rd3_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = 4'b1101; #1;
    chk("rd3_rsp", 32'(rsp_valid), 32'h8);
    chk("rd3_rdata", 32'(rsp_rdata), 32'hA5);

    // Req0/2/3 READ continuously: grants 0,2,3,0,2,3, response next cycle.
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_ready%0d", i), 32'(req_ready), 32'(exp_g[i]));
      @(negedge clk);
      if (i == 5) req_valid = '0;
      #1;
      chk($sformatf("rr_rsp%0d", i), 32'(rsp_valid), 32'(exp_g[i]));
      chk($sformatf("rr_rdata%0d", i), 32'(rsp_rdata), 32'(exp_d[i]));
    end
    chk("rr_soi_end", 32'(soi_value), 32'h5A);

    // Req2 HOLD; toggle still applies in the accept cycle (state was RUN).
    req_valid = 4'b0100; req_op = 8'h20; #1;
    chk("hold_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b0001; req_op = 8'h01; req_wdata = 32'h0000_0011; #1;
    chk("hold_held", 32'(soi_held), 32'h1);
    chk("hold_owner", 32'(lock_owner), 32'h2);
    chk("hold_rsp", 32'(rsp_valid), 32'h4);
    chk("hold_rdata", 32'(rsp_rdata), 32'h5A);
    chk("hold_soi", 32'(soi_value), 32'hA5);
    chk("hold_req0_stall", 32'(req_ready), 32'h0);
    @(negedge clk);
    req_valid = 4'b0101; req_op = 8'h11; req_wdata = 32'h003C_0011; #1;
    chk("hold_frozen", 32'(soi_value), 32'hA5);
    chk("hold_no_rsp", 32'(rsp_valid), 32'h0);
    chk("hold_owner_only", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_op = 8'h31; #1;
    chk("own_wr_soi", 32'(soi_value), 32'h3C);
    chk("own_wr_rsp", 32'(rsp_valid), 32'h4);
    chk("own_wr_rdata", 32'(rsp_rdata), 32'hA5);
    chk("own_wr_err", 32'(rsp_err), 32'h0);
    chk("rel_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b0001; #1;
    chk("rel_held", 32'(soi_held), 32'h0);
    chk("rel_owner", 32'(lock_owner), 32'h0);
    chk("rel_rsp", 32'(rsp_valid), 32'h4);
    chk("rel_err", 32'(rsp_err), 32'h0);
    chk("rel_soi", 32'(soi_value), 32'h3C);
    chk("req0_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    // Req3 RELEASE while unlocked is rejected.
    req_valid = 4'b1000; req_op = 8'hC0; #1;
    chk("req0_soi", 32'(soi_value), 32'h11);
    chk("req0_rsp", 32'(rsp_valid), 32'h1);
    chk("req0_rdata", 32'(rsp_rdata), 32'h3C);
    chk("relrun_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0; #1;
    chk("relrun_rsp", 32'(rsp_valid), 32'h8);
    chk("relrun_err", 32'(rsp_err), 32'h1);
    chk("relrun_held", 32'(soi_held), 32'h0);
    chk("relrun_soi", 32'(soi_value), 32'hEE);
    @(negedge clk);
    // Req1 HOLD, then reset while its response is showing.
    req_valid = 4'b0010; req_op = 8'h08; #1;
    chk("relrun_rsp_drop", 32'(rsp_valid), 32'h0);
    chk("relrun_err_drop", 32'(rsp_err), 32'h0);
    chk("h1_ready", 32'(req_ready), 32'h2);
    @(negedge clk); #1;
    chk("h1_rsp", 32'(rsp_valid), 32'h2);
    chk("h1_held", 32'(soi_held), 32'h1);
    chk("h1_owner", 32'(lock_owner), 32'h1);
    rst = 1'b1; #1;
    chk("mrst_rsp", 32'(rsp_valid), 32'h0);
    chk("mrst_held", 32'(soi_held), 32'h0);
    chk("mrst_owner", 32'(lock_owner), 32'h0);
    chk("mrst_soi", 32'(soi_value), 32'hFF);
    chk("mrst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0; req_valid = '0; #1;
    chk("post_rst_soi", 32'(soi_value), 32'hFF);
    @(negedge clk); #1;
    chk("post_rst_toggle", 32'(soi_value), 32'h00);
    chk("post_rst_rsp", 32'(rsp_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
